multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl_if.sv | 52 +++++
 rtl/multi_cycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl_if
// Purpose  : Bundle of instruction fields, datapath status and control
//            outputs exchanged between the multi-cycle controller and the
//            datapath.
// Revision : 1.0  initial release
// ============================================================================
interface multi_cycle_ctrl_if;
  // Instruction fields and datapath status flags
  logic [5:0] OpCode;
  logic [5:0] func;
  logic       zero;
  logic       gtz;
  logic       mem_ready;

  // Write enables and operand select
  logic       PCWr;
  logic       IRWr;
  logic       RegWrite;
  logic       MemWrite;
  logic       ALUSrc;

  // Multiplexer and operation selects
  logic [1:0] RegDst;
  logic [1:0] Mem_to_Reg;
  logic [1:0] Extop;
  logic [1:0] ALUop;
  logic [1:0] nPC_sel;

  // Status outputs
  logic [2:0] state;
  logic       illegal;
  logic       instr_done;

  // Controller side
  modport master (
    input  OpCode, func, zero, gtz, mem_ready,
    output PCWr, IRWr, RegWrite, MemWrite, ALUSrc,
    output RegDst, Mem_to_Reg, Extop, ALUop, nPC_sel,
    output state, illegal, instr_done
  );

  // Datapath side
  modport slave (
    output OpCode, func, zero, gtz, mem_ready,
    input  PCWr, IRWr, RegWrite, MemWrite, ALUSrc,
    input  RegDst, Mem_to_Reg, Extop, ALUop, nPC_sel,
    input  state, illegal, instr_done
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_ctrl
// Purpose  : Five-state (IF/ID/EXE/MEM/WB) control unit for a multi-cycle
//            MIPS-subset datapath. State is registered; all control outputs
//            are decoded combinationally from state, instruction fields and
//            datapath status.
// Revision : 1.0  initial release
// ============================================================================
module multi_cycle_ctrl (
  input  logic               clk,
  input  logic               reset,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_2 = 2'b10;
  localparam logic [1:0] SEL_3 = 2'b11;

  state_t     cur_state;
  state_t     nxt_state;

  // Instruction class decode
  logic       is_rtype, is_r_alu, is_jr, is_j, is_jal;
  logic       is_beq, is_bgtz, is_lw, is_sw, is_ori, is_lui, is_addi;
  logic       is_i_alu, goes_exe;

  // Datapath selects, valid for the whole EXE..WB span of one instruction
  logic [1:0] sel_regdst, sel_extop, sel_aluop;
  logic       sel_alusrc;

  // Unqualified control values, gated by reset before reaching the ports
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, ill, done;
  logic [1:0] reg_dst, mem_to_reg, ext_op, alu_op, npc_sel;

  assign is_rtype = (bus.OpCode == OP_RTYPE);
  assign is_r_alu = is_rtype && ((bus.func == FN_ADDU) || (bus.func == FN_SUBU) ||
                                 (bus.func == FN_SLT));
  assign is_jr    = is_rtype && (bus.func == FN_JR);
  assign is_j     = (bus.OpCode == OP_J);
  assign is_jal   = (bus.OpCode == OP_JAL);
  assign is_beq   = (bus.OpCode == OP_BEQ);
  assign is_bgtz  = (bus.OpCode == OP_BGTZ);
  assign is_lw    = (bus.OpCode == OP_LW);
  assign is_sw    = (bus.OpCode == OP_SW);
  assign is_ori   = (bus.OpCode == OP_ORI);
  assign is_lui   = (bus.OpCode == OP_LUI);
  assign is_addi  = (bus.OpCode == OP_ADDI) || (bus.OpCode == OP_ADDIU);
  assign is_i_alu = is_ori || is_lui || is_addi;
  assign goes_exe = is_r_alu || is_i_alu || is_beq || is_bgtz || is_lw || is_sw;

  // Datapath selects depend only on the instruction, so they stay constant
  // across EXE, MEM and WB while OpCode/func are held.
  always_comb begin
    sel_regdst = SEL_0;
    sel_alusrc = 1'b0;
    sel_extop  = SEL_0;
    sel_aluop  = SEL_0;
    if (is_r_alu) begin
      sel_regdst = SEL_1;
      if (bus.func == FN_SUBU)     sel_aluop = SEL_1;
      else if (bus.func == FN_SLT) sel_aluop = SEL_3;
      else                         sel_aluop = SEL_0;
    end else if (is_ori) begin
      sel_alusrc = 1'b1;
      sel_extop  = SEL_0;
      sel_aluop  = SEL_2;
    end else if (is_lui) begin
      sel_alusrc = 1'b1;
      sel_extop  = SEL_2;
    end else if (is_addi || is_lw || is_sw) begin
      sel_alusrc = 1'b1;
      sel_extop  = SEL_1;
    end else if (is_beq || is_bgtz) begin
      sel_aluop  = SEL_1;
    end
  end

  // Next-state and control decode for the current state
  always_comb begin
    nxt_state  = S_IF;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    alu_src    = 1'b0;
    ill        = 1'b0;
    reg_dst    = SEL_0;
    mem_to_reg = SEL_0;
    ext_op     = SEL_0;
    alu_op     = SEL_0;
    npc_sel    = SEL_0;
    case (cur_state)
      S_IF: begin
        if (bus.mem_ready) begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          nxt_state = S_ID;
        end else begin
          nxt_state = S_IF;
        end
      end
      S_ID: begin
        if (is_j) begin
          pc_wr   = 1'b1;
          npc_sel = SEL_2;
        end else if (is_jal) begin
          pc_wr      = 1'b1;
          npc_sel    = SEL_2;
          reg_wr     = 1'b1;
          reg_dst    = SEL_2;
          mem_to_reg = SEL_2;
        end else if (is_jr) begin
          pc_wr   = 1'b1;
          npc_sel = SEL_3;
        end else if (goes_exe) begin
          nxt_state = S_EXE;
        end else begin
          ill = 1'b1;
        end
      end
      S_EXE: begin
        reg_dst = sel_regdst;
        alu_src = sel_alusrc;
        ext_op  = sel_extop;
        alu_op  = sel_aluop;
        if (is_beq) begin
          npc_sel = SEL_1;
          pc_wr   = bus.zero;
        end else if (is_bgtz) begin
          npc_sel = SEL_1;
          pc_wr   = bus.gtz;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else if (is_r_alu || is_i_alu) begin
          nxt_state = S_WB;
        end
      end
      S_MEM: begin
        reg_dst = sel_regdst;
        alu_src = sel_alusrc;
        ext_op  = sel_extop;
        alu_op  = sel_aluop;
        if (!bus.mem_ready) begin
          nxt_state = S_MEM;
        end else if (is_sw) begin
          mem_wr = 1'b1;
        end else if (is_lw) begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        reg_dst    = sel_regdst;
        alu_src    = sel_alusrc;
        ext_op     = sel_extop;
        alu_op     = sel_aluop;
        reg_wr     = 1'b1;
        mem_to_reg = is_lw ? SEL_1 : SEL_0;
      end
      default: nxt_state = S_IF;
    endcase
    // An instruction retires in any real non-IF state that hands back to IF;
    // unused encodings are recovery, not instructions.
    done = (cur_state != S_IF) && (nxt_state == S_IF) &&
           ((cur_state == S_ID) || (cur_state == S_EXE) ||
            (cur_state == S_MEM) || (cur_state == S_WB));
  end

  // Write enables and pulses are forced low while reset is held so that a
  // pending store or register write cannot land during reset.
  assign bus.PCWr       = pc_wr  & ~reset;
  assign bus.IRWr       = ir_wr  & ~reset;
  assign bus.RegWrite   = reg_wr & ~reset;
  assign bus.MemWrite   = mem_wr & ~reset;
  assign bus.illegal    = ill    & ~reset;
  assign bus.instr_done = done   & ~reset;
  assign bus.ALUSrc     = alu_src;
  assign bus.RegDst     = reg_dst;
  assign bus.Mem_to_Reg = mem_to_reg;
  assign bus.Extop      = ext_op;
  assign bus.ALUop      = alu_op;
  assign bus.nPC_sel    = npc_sel;
  assign bus.state      = cur_state;

  // State register: reset returns to IF from any state
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= nxt_state;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_cycle_ctrl
// Purpose  : Directed self-checking bench for multi_cycle_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_cycle_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in IF with the fetch completing, then move to ID
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    bus.OpCode    = op;
    bus.func      = fn;
    bus.mem_ready = 1'b1;
    #1;
    check_val("if_state", int'(bus.state), 0);
    check_val("if_irwr", int'(bus.IRWr), 1);
    tick();
    check_val("id_state", int'(bus.state), 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.OpCode    = 6'b000000;
    bus.func      = 6'b000000;
    bus.zero      = 1'b0;
    bus.gtz       = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with a ready fetch: nothing may be written
    check_val("rst_state", int'(bus.state), 0);
    check_val("rst_pcwr", int'(bus.PCWr), 0);
    check_val("rst_irwr", int'(bus.IRWr), 0);
    check_val("rst_done", int'(bus.instr_done), 0);

    // First IF after reset with the memory not ready: hold
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check_val("ifhold_irwr", int'(bus.IRWr), 0);
    check_val("ifhold_pcwr", int'(bus.PCWr), 0);
    tick();
    check_val("ifhold_state", int'(bus.state), 0);

    // addu: IF, ID, EXE, WB, IF
    fetch(6'b000000, 6'b100001);
    check_val("addu_id_regwr", int'(bus.RegWrite), 0);
    check_val("addu_id_regdst", int'(bus.RegDst), 0);
    tick();
    check_val("addu_exe_state", int'(bus.state), 2);
    check_val("addu_exe_regwr", int'(bus.RegWrite), 0);
    check_val("addu_exe_done", int'(bus.instr_done), 0);
    tick();
    check_val("addu_wb_state", int'(bus.state), 4);
    check_val("addu_wb_regwr", int'(bus.RegWrite), 1);
    check_val("addu_wb_regdst", int'(bus.RegDst), 1);
    check_val("addu_wb_aluop", int'(bus.ALUop), 0);
    check_val("addu_wb_done", int'(bus.instr_done), 1);
    tick();
    check_val("addu_ret_state", int'(bus.state), 0);

    // lw with two wait cycles in MEM
    fetch(6'b100011, 6'b000000);
    tick();
    check_val("lw_exe_alusrc", int'(bus.ALUSrc), 1);
    check_val("lw_exe_extop", int'(bus.Extop), 1);
    check_val("lw_exe_aluop", int'(bus.ALUop), 0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check_val("lw_mem1_state", int'(bus.state), 3);
    check_val("lw_mem1_done", int'(bus.instr_done), 0);
    tick();
    check_val("lw_mem2_state", int'(bus.state), 3);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check_val("lw_mem3_state", int'(bus.state), 3);
    check_val("lw_mem3_regwr", int'(bus.RegWrite), 0);
    tick();
    check_val("lw_wb_state", int'(bus.state), 4);
    check_val("lw_wb_m2r", int'(bus.Mem_to_Reg), 1);
    check_val("lw_wb_regwr", int'(bus.RegWrite), 1);
    check_val("lw_wb_alusrc", int'(bus.ALUSrc), 1);
    check_val("lw_wb_done", int'(bus.instr_done), 1);
    tick();
    check_val("lw_ret_state", int'(bus.state), 0);

    // beq not taken, then taken
    for (int k = 0; k < 2; k++) begin
      fetch(6'b000100, 6'b000000);
      bus.zero = (k == 1);
      tick();
      check_val("beq_exe_state", int'(bus.state), 2);
      check_val("beq_pcwr", int'(bus.PCWr), k);
      check_val("beq_npc", int'(bus.nPC_sel), 1);
      check_val("beq_aluop", int'(bus.ALUop), 1);
      check_val("beq_done", int'(bus.instr_done), 1);
      tick();
      check_val("beq_ret_state", int'(bus.state), 0);
    end
    bus.zero = 1'b0;

    // bgtz taken on gtz while zero is low
    fetch(6'b000111, 6'b000000);
    bus.gtz = 1'b1;
    tick();
    check_val("bgtz_pcwr", int'(bus.PCWr), 1);
    check_val("bgtz_npc", int'(bus.nPC_sel), 1);
    tick();
    bus.gtz = 1'b0;
    check_val("bgtz_ret_state", int'(bus.state), 0);

    // jal: done in ID
    fetch(6'b000011, 6'b000000);
    check_val("jal_pcwr", int'(bus.PCWr), 1);
    check_val("jal_npc", int'(bus.nPC_sel), 2);
    check_val("jal_regwr", int'(bus.RegWrite), 1);
    check_val("jal_regdst", int'(bus.RegDst), 2);
    check_val("jal_m2r", int'(bus.Mem_to_Reg), 2);
    check_val("jal_done", int'(bus.instr_done), 1);
    tick();
    check_val("jal_ret_state", int'(bus.state), 0);

    // j and jr
    fetch(6'b000010, 6'b000000);
    check_val("j_npc", int'(bus.nPC_sel), 2);
    check_val("j_regwr", int'(bus.RegWrite), 0);
    tick();
    fetch(6'b000000, 6'b001000);
    check_val("jr_pcwr", int'(bus.PCWr), 1);
    check_val("jr_npc", int'(bus.nPC_sel), 3);
    check_val("jr_illegal", int'(bus.illegal), 0);
    tick();

    // Unknown opcode and unknown R-type func
    fetch(6'b111111, 6'b000000);
    check_val("ill_op_pulse", int'(bus.illegal), 1);
    check_val("ill_op_pcwr", int'(bus.PCWr), 0);
    check_val("ill_op_regwr", int'(bus.RegWrite), 0);
    check_val("ill_op_memwr", int'(bus.MemWrite), 0);
    tick();
    check_val("ill_op_ret_state", int'(bus.state), 0);
    check_val("ill_op_if_pulse", int'(bus.illegal), 0);
    fetch(6'b000000, 6'b000000);
    check_val("ill_fn_pulse", int'(bus.illegal), 1);
    tick();

    // ori, lui, subu, slt write-back selects
    fetch(6'b001101, 6'b000000);
    tick();
    check_val("ori_exe_aluop", int'(bus.ALUop), 2);
    tick();
    check_val("ori_wb_regdst", int'(bus.RegDst), 0);
    check_val("ori_wb_alusrc", int'(bus.ALUSrc), 1);
    check_val("ori_wb_extop", int'(bus.Extop), 0);
    check_val("ori_wb_aluop", int'(bus.ALUop), 2);
    tick();
    fetch(6'b001111, 6'b000000);
    tick();
    tick();
    check_val("lui_wb_extop", int'(bus.Extop), 2);
    check_val("lui_wb_alusrc", int'(bus.ALUSrc), 1);
    tick();
    fetch(6'b000000, 6'b100011);
    tick();
    tick();
    check_val("subu_wb_aluop", int'(bus.ALUop), 1);
    tick();
    fetch(6'b000000, 6'b101010);
    tick();
    tick();
    check_val("slt_wb_aluop", int'(bus.ALUop), 3);
    tick();

    // sw normal completion
    fetch(6'b101011, 6'b000000);
    tick();
    check_val("sw_exe_state", int'(bus.state), 2);
    tick();
    check_val("sw_mem_state", int'(bus.state), 3);
    check_val("sw_mem_memwr", int'(bus.MemWrite), 1);
    check_val("sw_mem_done", int'(bus.instr_done), 1);
    tick();
    check_val("sw_ret_state", int'(bus.state), 0);

    // sw interrupted by reset in MEM
    fetch(6'b101011, 6'b000000);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_val("swrst_state", int'(bus.state), 3);
    check_val("swrst_memwr", int'(bus.MemWrite), 0);
    check_val("swrst_done", int'(bus.instr_done), 0);
    tick();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check_val("swrst_next_state", int'(bus.state), 0);
    check_val("swrst_next_irwr", int'(bus.IRWr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
